// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and sizing helpers for the restoring divider control
package div_pkg;

    localparam int DIV_WIDTH = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } div_state_e;

    function automatic int div_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_iter_cnt.sv
// rtl/div_iter_cnt.sv - iteration counter with clear, increment and terminal count at WIDTH-1
module div_iter_cnt
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic clock,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    localparam int CNT_W = div_cnt_w(WIDTH);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign tc = (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clock) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - control FSM for the restoring shift/subtract divider
// Optional divide-by-zero short-cut enabled with `DIV_ZERO_CHK_EN.
module div_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic clock,
    input  logic rst,
    input  logic start,
    input  logic gt,
    input  logic dvsr_zero,
    input  logic ack,
    output logic ready,
    output logic q_init,
    output logic rem_init,
    output logic ldgt,
    output logic lds,
    output logic busy,
    output logic done,
    output logic err
);

    div_state_e state_d;
    div_state_e state_q;
    logic       cnt_clr;
    logic       cnt_inc;
    logic       cnt_tc;

    div_iter_cnt #(
        .WIDTH (WIDTH)
    ) u_iter_cnt (
        .clock (clock),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .tc    (cnt_tc)
    );

    always_comb begin
        state_d  = state_q;
        ready    = 1'b0;
        q_init   = 1'b0;
        rem_init = 1'b0;
        ldgt     = 1'b0;
        lds      = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_d = INIT;
                end
            end
            INIT: begin
                q_init   = 1'b1;
                rem_init = 1'b1;
                busy     = 1'b1;
                cnt_clr  = 1'b1;
                state_d  = ITER;
`ifdef DIV_ZERO_CHK_EN
                if (dvsr_zero) begin
                    state_d = DONE;
                end
`endif
            end
            ITER: begin
                busy    = 1'b1;
                ldgt    = gt;
                lds     = ~gt;
                cnt_inc = 1'b1;
                if (cnt_tc) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // start is deliberately not looked at here, even alongside ack
                done = 1'b1;
                if (ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef DIV_ZERO_CHK_EN
    logic err_d;
    logic err_q;

    always_comb begin
        err_d = err_q;
        if (state_q == INIT && dvsr_zero) begin
            err_d = 1'b1;
        end else if (state_q == DONE && ack) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic dvsr_zero_unused;
    assign dvsr_zero_unused = dvsr_zero;
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - scoreboard testbench for div_ctrl (WIDTH=10 main instance, WIDTH=4 side instance)
module tb_div_ctrl;
    import div_pkg::*;

    localparam int W = DIV_WIDTH;

    logic clock = 1'b0;
    logic rst, start, gt, dvsr_zero, ack;
    logic ready, q_init, rem_init, ldgt, lds, busy, done, err;
    logic start4, gt4, ack4;
    logic ready4, q_init4, rem_init4, ldgt4, lds4, busy4, done4, err4;

    always #5 clock = ~clock;

    div_ctrl #(.WIDTH(W)) dut (
        .clock(clock), .rst(rst), .start(start), .gt(gt), .dvsr_zero(dvsr_zero), .ack(ack),
        .ready(ready), .q_init(q_init), .rem_init(rem_init), .ldgt(ldgt), .lds(lds),
        .busy(busy), .done(done), .err(err)
    );

    div_ctrl #(.WIDTH(4)) dut4 (
        .clock(clock), .rst(rst), .start(start4), .gt(gt4), .dvsr_zero(1'b0), .ack(ack4),
        .ready(ready4), .q_init(q_init4), .rem_init(rem_init4), .ldgt(ldgt4), .lds(lds4),
        .busy(busy4), .done(done4), .err(err4)
    );

    typedef struct {
        logic [W-1:0] quot;
        logic         err;
        int           done_cyc;
    } res_t;

    res_t exp_res[$];
    logic exp_it[$];
    int   passed = 0;
    int   total = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    logic done_prev = 1'b0;
    logic [W-1:0] qm;

    always @(posedge clock) cyc <= cyc + 1;

    // quotient register as the datapath would build it from the control outputs
    always @(posedge clock) begin
        if (q_init) qm <= '0;
        else if (ldgt) qm <= {qm[W-2:0], 1'b1};
        else if (lds) qm <= {qm[W-2:0], 1'b0};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clock) begin
        if (ldgt || lds) begin
            if (exp_it.size() == 0) begin
                check("unexpected_iter", {30'd0, ldgt, lds}, 32'd0);
            end else begin
                logic e;
                e = exp_it.pop_front();
                check("iter_ldgt_lds", {30'd0, ldgt, lds}, {30'd0, e, ~e});
            end
        end
        if (done && !done_prev) begin
            if (exp_res.size() == 0) begin
                check("unexpected_done", {31'd0, done}, 32'd0);
            end else begin
                res_t r;
                r = exp_res.pop_front();
                check("quotient", 32'(qm), 32'(r.quot));
                check("err", {31'd0, err}, {31'd0, r.err});
                check("done_cycle", 32'(cyc - start_cyc + 1), 32'(r.done_cyc));
            end
        end
        done_prev = done;
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check_idle(input string name);
        check({name, "_ready"}, {31'd0, ready}, 32'd1);
        check({name, "_others"}, {25'd0, q_init, rem_init, ldgt, lds, busy, done, err}, 32'd0);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        check(name, {31'd0, done}, 32'd1);
    endtask

    task automatic run_div(input logic [W-1:0] pat, input int n_iter, input logic [W-1:0] eq,
                           input logic eerr, input int edc, input logic zero,
                           input int start_at, input int rst_at);
        res_t r;
        r.quot = eq;
        r.err = eerr;
        r.done_cyc = edc;
        if (rst_at < 0) exp_res.push_back(r);
        for (int i = 0; i < n_iter; i++) exp_it.push_back(pat[W-1-i]);
        dvsr_zero = zero;
        start = 1'b1;
        tick();
        start_cyc = cyc;
        start = 1'b0;
        check("init_cycle1", {29'd0, q_init, rem_init, busy}, 32'd7);
        tick();
        check("init_cycle2_off", {30'd0, q_init, rem_init}, 32'd0);
        for (int i = 0; i < W; i++) begin
            gt = pat[W-1-i];
            start = (i == start_at);
            if (i == rst_at) rst = 1'b0;
            tick();
            start = 1'b0;
            if (i == rst_at) begin
                rst = 1'b1;
                check_idle("after_mid_reset");
                dvsr_zero = 1'b0;
                return;
            end
        end
        gt = 1'b0;
        wait_done("done_reached");
        dvsr_zero = 1'b0;
    endtask

    task automatic do_ack;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("ready_after_ack", {31'd0, ready}, 32'd1);
    endtask

    initial begin
        int n;
        int pulses;
        int s4;
        rst = 1'b0; start = 1'b0; gt = 1'b0; dvsr_zero = 1'b0; ack = 1'b0;
        start4 = 1'b0; gt4 = 1'b1; ack4 = 1'b0;
        tick();
        tick();
        check_idle("reset");
        rst = 1'b1;
        tick();
        check_idle("post_reset");

        run_div(10'b1011001010, 10, 10'b1011001010, 1'b0, 12, 1'b0, -1, -1);
        do_ack();

        run_div(10'b1111111111, 10, 10'h3FF, 1'b0, 12, 1'b0, 3, -1);
        for (int k = 0; k < 5; k++) begin
            start = (k == 2);
            tick();
            start = 1'b0;
            check("done_held", {30'd0, done, busy}, 32'd2);
        end
        ack = 1'b1;
        start = 1'b1;
        tick();
        ack = 1'b0;
        start = 1'b0;
        check("ack_start_ready", {31'd0, ready}, 32'd1);
        tick();
        check("start_in_done_ignored", {30'd0, ready, q_init}, 32'd2);

        run_div(10'b0101010101, 6, '0, 1'b0, 0, 1'b0, -1, 5);
        tick();
        check_idle("idle_after_reset");
        run_div(10'b0000000001, 10, 10'b0000000001, 1'b0, 12, 1'b0, -1, -1);
        do_ack();

`ifdef DIV_ZERO_CHK_EN
        run_div(10'b0000000000, 0, 10'b0, 1'b1, 2, 1'b1, -1, -1);
`else
        run_div(10'b0000000000, 10, 10'b0, 1'b0, 12, 1'b1, -1, -1);
`endif
        do_ack();
        check("err_cleared", {31'd0, err}, 32'd0);

        start4 = 1'b1;
        tick();
        s4 = cyc;
        start4 = 1'b0;
        n = 0;
        pulses = 0;
        while (!done4 && n < 20) begin
            if (ldgt4 || lds4) pulses++;
            tick();
            n++;
        end
        check("w4_done", {31'd0, done4}, 32'd1);
        check("w4_done_cycle", 32'(cyc - s4 + 1), 32'd6);
        check("w4_iter_count", 32'(pulses), 32'd4);
        ack4 = 1'b1;
        tick();
        ack4 = 1'b0;
        check("w4_ready", {31'd0, ready4}, 32'd1);

        tick();
        check("scoreboard_drained", 32'(exp_res.size() + exp_it.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
